// File: rtl/key_expansion_seq_if.sv
// Control, status and round-key read signals between a key-schedule user and key_expansion_seq.
interface key_expansion_seq_if #(
  parameter int KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                key_clear;
  logic                busy;
  logic                done;
  logic                key_valid;
  logic [3:0]          rk_rd_idx;
  logic [127:0]        rk_rd_data;

  // Cipher core / key loader side
  modport master (
    output start, key_in, key_clear, rk_rd_idx,
    input  busy, done, key_valid, rk_rd_data
  );

  // Key schedule side
  modport slave (
    input  start, key_in, key_clear, rk_rd_idx,
    output busy, done, key_valid, rk_rd_data
  );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule (128/192/256-bit keys): one 32-bit schedule word per clock
// into a round-key store, with a registered 128-bit round-key read port.

// Combinational AES S-box (FIPS-197 forward substitution table).
module key_expansion_seq_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];
endmodule

module key_expansion_seq #(
  parameter int KEY_BITS = 128
) (
  input logic               clk,
  input logic               rst_n,
  key_expansion_seq_if.slave bus
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("key_expansion_seq: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       state_q, state_d;
  logic [5:0]   i_q, i_d;          // index of the next schedule word to write
  logic [2:0]   wrap_q, wrap_d;    // i mod NK, kept incrementally to avoid a divider
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         key_valid_q, key_valid_d;
  logic [31:0]  w_q [NW];
  logic [31:0]  w_d [NW];
  logic [127:0] rk_rd_data_q, rk_rd_data_d;

  logic [5:0]   prev_idx, back_idx, rd_base;
  logic [31:0]  prev_word, back_word, sub_in, sub_out, t_word;

  // Only w[i-1] and w[i-NK] feed the recurrence; indices are clamped so they stay in range outside EXPAND.
  assign prev_idx  = (i_q == 6'd0) ? 6'd0 : i_q - 6'd1;
  assign back_idx  = (i_q < 6'(NK)) ? 6'd0 : i_q - 6'(NK);
  assign prev_word = w_q[prev_idx];
  assign back_word = w_q[back_idx];
  assign sub_in    = (wrap_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    key_expansion_seq_sbox u_sbox (
      .in_byte  (sub_in[8*gi +: 8]),
      .out_byte (sub_out[8*gi +: 8])
    );
  end

  // Select the recurrence term t for the word being generated this cycle.
  always_comb begin
    if (wrap_q == 3'd0)                 t_word = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && wrap_q == 3'd4) t_word = sub_out;
    else                                t_word = prev_word;
  end

  // Next-state logic: key_clear dominates, then load on start from IDLE/READY, then one word per EXPAND cycle.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    wrap_d      = wrap_q;
    rcon_d      = rcon_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    w_d         = w_q;
    if (bus.key_clear) begin
      for (int k = 0; k < NW; k++) w_d[k] = '0;
      state_d     = IDLE;
      i_d         = '0;
      wrap_d      = '0;
      rcon_d      = 8'h01;
      busy_d      = 1'b0;
      key_valid_d = 1'b0;
    end else begin
      case (state_q)
        EXPAND: begin
          w_d[i_q] = back_word ^ t_word;
          i_d      = i_q + 6'd1;
          wrap_d   = (wrap_q == 3'(NK - 1)) ? 3'd0 : wrap_q + 3'd1;
          if (wrap_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          if (i_q == 6'(NW - 1)) begin
            state_d     = READY;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            key_valid_d = 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            for (int k = 0; k < NK; k++) w_d[k] = bus.key_in[KEY_BITS-1-32*k -: 32];
            state_d     = EXPAND;
            i_d         = 6'(NK);
            wrap_d      = '0;
            rcon_d      = 8'h01;
            busy_d      = 1'b1;
            key_valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  // Round-key read mux; indices beyond NR read as zero.
  assign rd_base = {bus.rk_rd_idx, 2'b00};
  always_comb begin
    rk_rd_data_d = '0;
    if (bus.rk_rd_idx <= 4'(NR))
      rk_rd_data_d = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
  end

  // All state, the word store and registered outputs; reset discards any partial schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      i_q          <= '0;
      wrap_q       <= '0;
      rcon_q       <= 8'h01;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      key_valid_q  <= 1'b0;
      rk_rd_data_q <= '0;
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      wrap_q       <= wrap_d;
      rcon_q       <= rcon_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      key_valid_q  <= key_valid_d;
      rk_rd_data_q <= rk_rd_data_d;
      for (int k = 0; k < NW; k++) w_q[k] <= w_d[k];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.rk_rd_data = rk_rd_data_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: three instances (128/192/256-bit keys) driven in parallel,
// checked every cycle against a FIPS-197 level key-schedule model plus literal round keys.
module tb_key_expansion_seq;
  logic clk;
  logic rst_n;
  logic start;
  logic key_clear;
  logic [3:0] rd_idx;
  logic sweep;
  logic run_cmp;
  logic [255:0] key_v [3];

  logic busy_a [3];
  logic done_a [3];
  logic valid_a [3];
  logic [127:0] rd_a [3];

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] KEY_SPEC0 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_SPEC1 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY_SPEC2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_ALT   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  key_expansion_seq_if #(.KEY_BITS(128)) bus0 ();
  key_expansion_seq_if #(.KEY_BITS(192)) bus1 ();
  key_expansion_seq_if #(.KEY_BITS(256)) bus2 ();

  key_expansion_seq #(.KEY_BITS(128)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  key_expansion_seq #(.KEY_BITS(192)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  key_expansion_seq #(.KEY_BITS(256)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.start = start;  assign bus0.key_clear = key_clear;  assign bus0.rk_rd_idx = rd_idx;
  assign bus1.start = start;  assign bus1.key_clear = key_clear;  assign bus1.rk_rd_idx = rd_idx;
  assign bus2.start = start;  assign bus2.key_clear = key_clear;  assign bus2.rk_rd_idx = rd_idx;
  assign bus0.key_in = key_v[0][255 -: 128];
  assign bus1.key_in = key_v[1][255 -: 192];
  assign bus2.key_in = key_v[2];

  assign busy_a[0] = bus0.busy;  assign done_a[0] = bus0.done;  assign valid_a[0] = bus0.key_valid;  assign rd_a[0] = bus0.rk_rd_data;
  assign busy_a[1] = bus1.busy;  assign done_a[1] = bus1.done;  assign valid_a[1] = bus1.key_valid;  assign rd_a[1] = bus1.rk_rd_data;
  assign busy_a[2] = bus2.busy;  assign done_a[2] = bus2.done;  assign valid_a[2] = bus2.key_valid;  assign rd_a[2] = bus2.rk_rd_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  logic [7:0]  sb [256];
  logic [31:0] pend  [3][64];
  logic [31:0] sched [3][64];
  bit          m_busy [3];
  bit          m_done [3];
  bit          m_valid [3];
  bit          m_known [3];
  int          m_cnt [3];
  logic [127:0] rd_exp [3];
  bit          rd_chk [3];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // Whole schedule for instance d from a left-aligned key.
  task automatic model_expand(input int d, input logic [255:0] key);
    int nk, nw;
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * d;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < 64; i++) pend[d][i] = 32'h0;
    for (int i = 0; i < nk; i++) pend[d][i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = pend[d][i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      pend[d][i] = pend[d][i-nk] ^ t;
    end
  endtask

  // Cycle-level behaviour: expansion lasts NW-NK edges after the start edge.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_busy[d] = 0; m_done[d] = 0; m_valid[d] = 0; m_known[d] = 1; m_cnt[d] = 0;
        for (int i = 0; i < 64; i++) sched[d][i] = 32'h0;
        rd_exp[d] = '0; rd_chk[d] = 1;
      end else begin
        int r;
        r = int'(rd_idx);
        rd_chk[d] = m_known[d];
        rd_exp[d] = '0;
        if (r <= 4 + 2*d + 6)
          rd_exp[d] = {sched[d][4*r], sched[d][4*r+1], sched[d][4*r+2], sched[d][4*r+3]};
        m_done[d] = 0;
        if (key_clear) begin
          for (int i = 0; i < 64; i++) sched[d][i] = 32'h0;
          m_busy[d] = 0; m_valid[d] = 0; m_known[d] = 1;
        end else if (start && !m_busy[d]) begin
          model_expand(d, key_v[d]);
          m_busy[d] = 1; m_valid[d] = 0; m_known[d] = 0; m_cnt[d] = 0;
        end else if (m_busy[d]) begin
          m_cnt[d]++;
          if (m_cnt[d] == 4 * (4 + 2*d + 7) - (4 + 2*d)) begin
            m_busy[d] = 0; m_done[d] = 1; m_valid[d] = 1; m_known[d] = 1;
            for (int i = 0; i < 64; i++) sched[d][i] = pend[d][i];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("dut%0d busy", d), 128'(busy_a[d]), 128'(m_busy[d]));
        chk($sformatf("dut%0d done", d), 128'(done_a[d]), 128'(m_done[d]));
        chk($sformatf("dut%0d key_valid", d), 128'(valid_a[d]), 128'(m_valid[d]));
        if (rd_chk[d]) chk($sformatf("dut%0d rk_rd_data idx%0d", d, rd_idx), rd_a[d], rd_exp[d]);
      end
    end
  end

  // Free-running read index sweep, including indices above NR.
  always @(posedge clk) begin
    #3;
    if (sweep) rd_idx = rd_idx + 4'd1;
  end

  // ---------------- stimulus ----------------
  int done_at [3];

  task automatic run_expand(input int mid_start_at, input int rst_at, input bit check_time);
    @(posedge clk); #1 start = 1; sweep = 1;
    @(posedge clk); #1 start = 0;
    for (int d = 0; d < 3; d++) done_at[d] = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) if (done_a[d] && done_at[d] == 0) done_at[d] = k;
      start = (k == mid_start_at);
      if (k == mid_start_at) for (int d = 0; d < 3; d++) key_v[d] = KEY_ALT;
      if (k == rst_at) rst_n = 0;
      if (k == rst_at + 2) rst_n = 1;
    end
    start = 0;
    if (check_time) begin
      chk("done latency 128", 128'(done_at[0]), 128'd40);
      chk("done latency 192", 128'(done_at[1]), 128'd46);
      chk("done latency 256", 128'(done_at[2]), 128'd52);
    end
  endtask

  task automatic lit_read(input int d, input logic [3:0] idx, input logic [127:0] exp, input string name);
    sweep = 0;
    @(posedge clk); #3 rd_idx = idx;
    @(posedge clk); #1 chk(name, rd_a[d], exp);
  endtask

  task automatic spec_literals();
    lit_read(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "dut0 idx1");
    lit_read(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "dut0 idx10");
    lit_read(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "dut1 idx12");
    lit_read(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "dut2 idx14");
  endtask

  initial begin
    start = 0; key_clear = 0; rd_idx = 4'd0; sweep = 0; run_cmp = 0;
    key_v[0] = KEY_SPEC0; key_v[1] = KEY_SPEC1; key_v[2] = KEY_SPEC2;
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset dut%0d busy", d), 128'(busy_a[d]), 128'd0);
      chk($sformatf("reset dut%0d done", d), 128'(done_a[d]), 128'd0);
      chk($sformatf("reset dut%0d key_valid", d), 128'(valid_a[d]), 128'd0);
      chk($sformatf("reset dut%0d rk_rd_data", d), rd_a[d], 128'd0);
    end

    // Pin the model against published round keys.
    build_sbox();
    model_expand(0, KEY_SPEC0);
    chk("model 128 idx1", {pend[0][4], pend[0][5], pend[0][6], pend[0][7]}, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model 128 idx10", {pend[0][40], pend[0][41], pend[0][42], pend[0][43]}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    model_expand(1, KEY_SPEC1);
    chk("model 192 idx12", {pend[1][48], pend[1][49], pend[1][50], pend[1][51]}, 128'he98ba06f448c773c8ecc720401002202);
    model_expand(2, KEY_SPEC2);
    chk("model 256 idx14", {pend[2][56], pend[2][57], pend[2][58], pend[2][59]}, 128'hfe4890d1e6188d0b046df344706c631e);

    @(posedge clk); #1 run_cmp = 1;
    @(posedge clk); #1 rst_n = 1;

    // T1-T3 with an ignored second start at cycle 10 (T4)
    run_expand(10, -10, 1);
    spec_literals();
    // T4: restart from READY with a new key
    run_expand(0, -10, 1);
    // T5: reset mid-expansion, then a full restart
    for (int d = 0; d < 3; d++) key_v[0] = KEY_SPEC0;
    key_v[1] = KEY_SPEC1; key_v[2] = KEY_SPEC2;
    run_expand(0, 20, 0);
    run_expand(0, -10, 1);
    spec_literals();

    // T6: key_clear beats start while READY
    sweep = 1;
    @(posedge clk); #1 key_clear = 1; start = 1;
    @(posedge clk); #1 key_clear = 0; start = 0;
    repeat (60) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("clear dut%0d key_valid", d), 128'(valid_a[d]), 128'd0);
    lit_read(0, 4'd15, 128'd0, "clear dut0 idx15");
    lit_read(2, 4'd15, 128'd0, "clear dut2 idx15");
    lit_read(0, 4'd1,  128'd0, "clear dut0 idx1");
    lit_read(2, 4'd14, 128'd0, "clear dut2 idx14");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
